// File: rtl/inst_rom_loader_pkg.sv
// Shared widths and loader state encoding for the instruction ROM and its byte-stream boot loader.
package inst_rom_loader_pkg;

  localparam int unsigned RegBusW      = 32;
  localparam int unsigned InstAddrBusW = 32;
  localparam int unsigned DefAddrWidth = 10;
  localparam int unsigned InstMemNum   = 1 << DefAddrWidth;

  typedef logic [RegBusW-1:0]      reg_bus_t;
  typedef logic [InstAddrBusW-1:0] inst_addr_bus_t;
  typedef logic [DefAddrWidth-1:0] inst_mem_addr_bus_t;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StRun
  } ld_state_e;

endpackage

// File: rtl/inst_rom_array.sv
// Word-organised instruction array: registered write port, combinational gated fetch port.
module inst_rom_array
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  ce_i,
  input  inst_addr_bus_t        addr_i,
  output reg_bus_t              data_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  reg_bus_t              wdata_i
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  reg_bus_t mem [Depth];

  // Fetch addresses are byte addresses; the low two bits never select anything.
  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    data_o = '0;
    if (ce_i && (addr_i[InstAddrBusW-1:ADDR_WIDTH+2] == '0)) begin
      data_o = mem[addr_i[ADDR_WIDTH+1:2]];
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with a boot loader: holds the core in reset while a counted,
// big-endian word stream is written from address 0, then serves fetches.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce_i,
  input  inst_addr_bus_t addr_i,
  output reg_bus_t       data_o,
  input  logic           ld_valid_i,
  input  logic [7:0]     ld_byte_i,
  output logic           ld_ready_o,
  output logic           cpu_rst_o,
  output logic           load_done_o,
  output logic           err_o
);

  ld_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] widx_q, widx_d;
  logic [1:0]           bsel_q, bsel_d;
  logic [23:0]          word_q, word_d;
  logic                 err_q, err_d;
  logic                 ld_ready_q, ld_ready_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d;

  logic                 xfer;
  logic                 we;
  logic                 widx_in_range;
  reg_bus_t             wdata;

  assign xfer          = ld_valid_i && ld_ready_q;
  assign widx_in_range = (widx_q >> ADDR_WIDTH) == '0;
  assign wdata         = {word_q, ld_byte_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bsel_d  = bsel_q;
    word_d  = word_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StHdr0;
      StHdr0: begin
        if (xfer) begin
          cnt_d   = {{(CNT_WIDTH-8){1'b0}}, ld_byte_i};
          state_d = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          cnt_d   = {cnt_q[CNT_WIDTH-9:0], ld_byte_i};
          state_d = (cnt_d == '0) ? StRun : StData;
        end
      end
      StData: begin
        if (xfer) begin
          bsel_d = bsel_q + 2'd1;
          if (bsel_q != 2'd3) begin
            word_d = {word_q[15:0], ld_byte_i};
          end else begin
            // Words past the array end are dropped rather than wrapped onto low addresses.
            if (widx_in_range) begin
              we = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            widx_d = widx_q + 1'b1;
            if (widx_d == cnt_q) begin
              state_d = StRun;
            end
          end
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
    ld_ready_d = (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData);
    cpu_rst_d  = (state_d != StRun);
    done_d     = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      widx_q     <= '0;
      bsel_q     <= 2'd0;
      word_q     <= '0;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      bsel_q     <= bsel_d;
      word_q     <= word_d;
      err_q      <= err_d;
      ld_ready_q <= ld_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
    end
  end

  assign ld_ready_o  = ld_ready_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign load_done_o = done_q;
  assign err_o       = err_q;

  inst_rom_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .ce_i    (ce_i),
    .addr_i  (addr_i),
    .data_o  (data_o),
    .we_i    (we),
    .waddr_i (widx_q[ADDR_WIDTH-1:0]),
    .wdata_i (wdata)
  );

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction memory for the core's fetch port, with a byte-stream boot loader. After reset it holds the core in reset. It accepts a 16-bit word count followed by that many big-endian 32-bit instruction words and writes them to consecutive word addresses from 0. It then releases the core and serves fetches on the `rom_addr_o`/`rom_ce_o`/`rom_data_i` interface as the responder, with the same combinational-read timing the core's `if_id` stage captures.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, word-address width; depth = 2^ADDR_WIDTH words
- `CNT_WIDTH`, 16, header word-count width (fixed two header bytes)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `ce_i`  in  1  fetch enable, driven by core `rom_ce_o`
- `addr_i`  in  32  fetch byte address, driven by core `rom_addr_o`
- `data_o`  out  32  fetched instruction, drives core `rom_data_i`
- `ld_valid_i`  in  1  loader byte valid
- `ld_byte_i`  in  8  loader byte
- `ld_ready_o`  out  1  loader byte ready; a byte transfers on a clock edge with `ld_valid_i && ld_ready_o`
- `cpu_rst_o`  out  1  active-high reset to the core, matching the core's `rst` polarity
- `load_done_o`  out  1  load complete; sticky until `rst`
- `err_o`  out  1  overflow; sticky until `rst`

## Operation
- Loader FSM states:
  - IDLE: reset state; advances to HDR0 unconditionally.
  - HDR0: accepted byte becomes count[15:8]; advances to HDR1.
  - HDR1: accepted byte becomes count[7:0]. If the 16-bit count is 0, go to RUN; otherwise go to DATA.
  - DATA: 2-bit byte counter `bsel`. The first byte goes to bits 31:24, the last to bits 7:0.
    - When the 4th byte is accepted, the assembled word is written at word index `widx`; `widx` increments and `bsel` wraps to 0.
    - When `widx`+1 == count on that 4th byte, go to RUN.
  - RUN: terminal until `rst`.
- `ld_ready_o` = 1 in HDR0, HDR1 and DATA; 0 in IDLE and RUN. Bytes presented in RUN are ignored.
- Overflow: a completed word with `widx` >= 2^ADDR_WIDTH is discarded, not written and not wrapped. `err_o` sets to 1, and loading continues to consume bytes until count is reached.
- `cpu_rst_o` = 1 in every state except RUN. `load_done_o` = 1 in RUN.
- Fetch read is combinational:
  - `data_o` = mem[`addr_i`[ADDR_WIDTH+1:2]] when `ce_i`=1 and `addr_i`[31:ADDR_WIDTH+2]=0.
  - `data_o` = 0 otherwise, including `ce_i`=0 and out-of-range addresses.
  - `addr_i`[1:0] is ignored.
- Memory is not cleared by reset. Fetches are meaningful only after RUN is reached.

## Timing
- Reset values, while `rst`=0: state IDLE, `ld_ready_o`=0, `cpu_rst_o`=1, `load_done_o`=0, `err_o`=0, `bsel`=0, `widx`=0, count=0.
- `rst` rising: one cycle in IDLE, then `ld_ready_o`=1 from the 2nd edge on.
- One byte per cycle maximum. `ld_valid_i` may drop at any time; no state advances without a transfer.
- Memory write lands on the edge that accepts the 4th byte. A read of that word is valid on the following cycle.
- FSM enters RUN, and `cpu_rst_o` falls, on the edge accepting the final byte (or HDR1's byte when count=0). The core's first fetch of address 0 sees the final word.
- `rst` asserted mid-load aborts immediately to the reset values. Words already written remain; the next load overwrites from index 0.
- Read-while-write cannot collide, because the core is held in reset throughout loading.

## Structure
- Shared package: add to `defines.v`:
  - `InstMemAddrBus`: ADDR_WIDTH-derived index range.
  - `InstMemNum`: depth.
  - Loader state encodings: IDLE, HDR0, HDR1, DATA, RUN.
  - Reuse `RegBus` and `InstAddrBus`.
- One sub-module, `inst_rom_array`: a 2^ADDR_WIDTH × 32 array with a registered write port (`we`, `waddr`, `wdata`) and a combinational read port with the `ce`/range gating.
- The FSM, byte assembly and counters stay in the top module.

## Test plan
- Reset then idle: hold `rst`=0 for 3 cycles.
  - Outputs are `ld_ready_o`=0, `cpu_rst_o`=1, `load_done_o`=0, `err_o`=0.
  - After release, `ld_ready_o`=1 from the 2nd edge.
- Basic load: bytes 00 02 34 01 00 05 34 02 00 0A.
  - mem[0]=0x34010005 and mem[1]=0x3402000A.
  - `cpu_rst_o` falls on the last byte.
  - `addr_i`=0x4 with `ce_i`=1 gives `data_o`=0x3402000A; with `ce_i`=0, `data_o`=0.
- Zero count: bytes 00 00 → RUN right after HDR1. `load_done_o`=1, `err_o`=0, and the following bytes are ignored with `ld_ready_o`=0.
- Valid gaps: the basic load with `ld_valid_i` low for 1–3 random cycles between bytes produces identical memory contents and an identical `cpu_rst_o` release relative to the last transfer.
- Overflow with ADDR_WIDTH=2: count 5, words 0x11111111..0x55555555.
  - mem[0..3] hold the first four words.
  - The 5th word is dropped, `err_o`=1, and RUN is reached after 22 bytes.
  - `addr_i`=0x10 reads 0.
- Mid-load reset: assert `rst` after 6 bytes of the basic load.
  - Reset values restored immediately.
  - A fresh load of 00 01 DE AD BE EF gives mem[0]=0xDEADBEEF and release.
